fp_adder: RTL and testbench
===========================

Name: fp_adder

Overview:
- Multi-cycle IEEE-754 single-precision (binary32) floating-point adder.
- Operands A and B are accepted over independent valid/ack (strobe/ack) handshakes; the sum is returned over a third handshake.
- Sits as the add unit of the FPU datapath; one operation in flight at a time.

Parameters:
- none (fixed binary32 format)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset (rst=0 holds block in reset)
- input_a  input  32  operand A, binary32
- input_b  input  32  operand B, binary32
- input_a_stb  input  1  operand A valid
- input_b_stb  input  1  operand B valid
- ack_output  input  1  consumer has taken output_z
- start  input  1  level enable; an operation begins only while start=1 in IDLE
- output_z  output  32  sum, binary32
- output_z_stb  output  1  output_z valid
- input_a_ack  output  1  operand A accepted
- input_b_ack  output  1  operand B accepted

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - output_z=0, output_z_stb=0, input_a_ack=0, input_b_ack=0.
  - All internal registers cleared.
- FSM states: IDLE, GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0, ADD1, NORM1, NORM2, ROUND, PACK, PUT_Z.
- IDLE: if start=1, go to GET_A; otherwise stay in IDLE.
- GET_A:
  - input_a_ack=1.
  - When input_a_ack & input_a_stb: latch input_a, drop ack, go to GET_B.
- GET_B: same rules as GET_A, using input_b / input_b_ack / input_b_stb.
- UNPACK:
  - Split each operand into sign, 8-bit exponent (unbiased = e-127) and 24-bit mantissa with hidden bit.
  - Mantissas are extended with 3 guard/round/sticky bits (27-bit working value).
- SPECIAL (checked in this priority order, each result goes to PUT_Z):
  - Either operand NaN -> 0x7FC00000.
  - A inf: B inf with opposite sign -> 0x7FC00000; otherwise A.
  - B inf -> B.
  - Both zero -> sign = sA & sB, exponent and mantissa 0.
  - A zero -> B.
  - B zero -> A.
  - Denormals: exponent treated as -126, hidden bit 0.
  - All other cases go to ALIGN.
- ALIGN:
  - Shift the smaller-exponent mantissa right by 1 and increment its exponent per cycle until exponents match.
  - Bit shifted out of LSB ORs into sticky.
- ADD0:
  - Same signs: add magnitudes, sign kept.
  - Different signs: subtract smaller magnitude from larger; result takes the sign of the larger.
  - Sum is 28 bits.
- ADD1:
  - If sum bit 27 is set: shift right 1 (sticky OR), exponent+1.
  - Take 24-bit mantissa and guard/round/sticky.
- NORM1: while mantissa[23]=0 and exponent > -126: shift left 1 (guard enters LSB), exponent-1.
- NORM2: while exponent < -126: shift right 1, exponent+1, sticky accumulates.
- ROUND:
  - Round-to-nearest-even: increment if guard & (round | sticky | mantissa[0]).
  - Mantissa overflow to 2^24: exponent+1.
- PACK:
  - Exponent = unbiased + 127.
  - If exponent = -126 and mantissa[23]=0: exponent field 0 (denormal).
  - If exponent > 127: result inf with sign kept.
  - Exact zero from cancellation yields +0.
- PUT_Z:
  - output_z_stb=1 with output_z stable.
  - When output_z_stb & ack_output: drop stb, return to IDLE.
- Latency: variable; at least 11 cycles from B accept to output_z_stb for aligned, normal operands.
- Inputs are ignored outside their GET state; ack is never asserted outside GET_A/GET_B.
- start falling mid-operation has no effect; the operation completes.

Decomposition:
- Shared package fp_pkg holds:
  - binary32 field widths;
  - bias 127 and EMIN -126;
  - constants QNAN=0x7FC00000 and POS_INF=0x7F800000;
  - the FSM state enum.
- Single module; no sub-module required. A round_rne helper function may live in fp_pkg.

Test Plan:
- 0x417C0000 (15.75) + 0x40E80000 (7.25), start=1, all stb/ack tied high -> output_z=0x41B80000 (23.0) with output_z_stb=1.
- 0x3F800000 + 0xBF800000 -> 0x00000000; 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Rounding ties: 0x3F800000 + 0x33800000 -> 0x3F800000; 0x3F800001 + 0x33800000 -> 0x3F800002.
- Denormal/overflow: 0x00000001 + 0x00000001 -> 0x00000002; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
- Handshake: hold input_b_stb=0 -> FSM waits in GET_B with input_b_ack=1. Hold ack_output=0 -> output_z_stb stays 1 and output_z stays stable. start=0 -> no acks asserted.
- Reset: drive rst=0 mid-operation (e.g. in ALIGN) -> all outputs 0 immediately, asynchronously. After rst=1, a fresh operation works correctly.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 constants, FSM state encoding and the RNE rounding helper
// used by the multi-cycle floating-point adder.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int WORD_W = 32;

   localparam logic signed [9:0] BIAS      = 10'sd127;
   localparam logic signed [9:0] EMIN      = -10'sd126;
   localparam logic signed [9:0] EMAX      = 10'sd127;
   localparam logic signed [9:0] E_DENORM  = -10'sd127;
   localparam logic signed [9:0] E_SPECIAL = 10'sd128;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [3:0] {
      IDLE, GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0,
      ADD1, NORM1, NORM2, ROUND, PACK, PUT_Z
   } state_e;

   function automatic logic [24:0] round_rne(
      input logic [23:0] m,
      input logic        g,
      input logic        r,
      input logic        s
   );
      logic inc;
      inc = g & (r | s | m[0]);
      return {1'b0, m} + {24'd0, inc};
   endfunction

endpackage

// File: rtl/fp_adder_if.sv
// Operand/result strobe-ack bundle between the FPU issue logic
// and the add unit.
interface fp_adder_if;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic        input_a_stb;
   logic        input_b_stb;
   logic        ack_output;
   logic        start;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        input_a_ack;
   logic        input_b_ack;

   modport master (
      output input_a, input_b, input_a_stb, input_b_stb,
      output ack_output, start,
      input  output_z, output_z_stb, input_a_ack, input_b_ack
   );

   modport slave (
      input  input_a, input_b, input_a_stb, input_b_stb,
      input  ack_output, start,
      output output_z, output_z_stb, input_a_ack, input_b_ack
   );
endinterface

// File: rtl/fp_adder.sv
// Multi-cycle binary32 adder: one operation in flight, serial align and
// normalise, round-to-nearest-even.
module fp_adder
   import fp_pkg::*;
(
   input logic     clk,
   input logic     rst,
   fp_adder_if.slave bus
);

   state_e state_q, state_d;

   logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
   logic [26:0] a_m_q, a_m_d, b_m_q, b_m_d;
   logic [27:0] sum_q, sum_d;
   logic [23:0] z_m_q, z_m_d;
   logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
   logic a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
   logic g_q, g_d, r_q, r_d, s_q, s_d;
   logic z_stb_q, z_stb_d, a_ack_q, a_ack_d, b_ack_q, b_ack_d;

   logic a_frac_nz, b_frac_nz;
   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [24:0] rnd;
   logic signed [9:0] biased;

   assign a_frac_nz = |a_m_q[25:3];
   assign b_frac_nz = |b_m_q[25:3];
   assign a_nan  = (a_e_q == E_SPECIAL) && a_frac_nz;
   assign b_nan  = (b_e_q == E_SPECIAL) && b_frac_nz;
   assign a_inf  = (a_e_q == E_SPECIAL) && !a_frac_nz;
   assign b_inf  = (b_e_q == E_SPECIAL) && !b_frac_nz;
   assign a_zero = (a_e_q == E_DENORM) && !a_frac_nz;
   assign b_zero = (b_e_q == E_DENORM) && !b_frac_nz;
   assign rnd    = round_rne(z_m_q, g_q, r_q, s_q);
   assign biased = z_e_q + BIAS;

   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      z_d = z_q;
      a_m_d = a_m_q;
      b_m_d = b_m_q;
      sum_d = sum_q;
      z_m_d = z_m_q;
      a_e_d = a_e_q;
      b_e_d = b_e_q;
      z_e_d = z_e_q;
      a_s_d = a_s_q;
      b_s_d = b_s_q;
      z_s_d = z_s_q;
      g_d = g_q;
      r_d = r_q;
      s_d = s_q;
      z_stb_d = z_stb_q;
      a_ack_d = a_ack_q;
      b_ack_d = b_ack_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) state_d = GET_A;
         end
         GET_A: begin
            a_ack_d = 1'b1;
            if (a_ack_q && bus.input_a_stb) begin
               a_d = bus.input_a;
               a_ack_d = 1'b0;
               state_d = GET_B;
            end
         end
         GET_B: begin
            b_ack_d = 1'b1;
            if (b_ack_q && bus.input_b_stb) begin
               b_d = bus.input_b;
               b_ack_d = 1'b0;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            a_m_d = {1'b0, a_q[22:0], 3'b000};
            b_m_d = {1'b0, b_q[22:0], 3'b000};
            a_e_d = $signed({2'b00, a_q[30:23]}) - BIAS;
            b_e_d = $signed({2'b00, b_q[30:23]}) - BIAS;
            a_s_d = a_q[31];
            b_s_d = b_q[31];
            state_d = SPECIAL;
         end
         SPECIAL: begin
            state_d = PUT_Z;
            if (a_nan || b_nan) begin
               z_d = QNAN;
            end else if (a_inf) begin
               z_d = (b_inf && (a_s_q != b_s_q)) ? QNAN : a_q;
            end else if (b_inf) begin
               z_d = b_q;
            end else if (a_zero && b_zero) begin
               z_d = {a_s_q & b_s_q, 31'd0};
            end else if (a_zero) begin
               z_d = b_q;
            end else if (b_zero) begin
               z_d = a_q;
            end else begin
               // Denormals keep hidden bit 0 but share the EMIN scale
               if (a_e_q == E_DENORM) a_e_d = EMIN;
               else a_m_d[26] = 1'b1;
               if (b_e_q == E_DENORM) b_e_d = EMIN;
               else b_m_d[26] = 1'b1;
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            if (a_e_q > b_e_q) begin
               b_e_d = b_e_q + 10'sd1;
               b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
            end else if (a_e_q < b_e_q) begin
               a_e_d = a_e_q + 10'sd1;
               a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
            end else begin
               state_d = ADD0;
            end
         end
         ADD0: begin
            z_e_d = a_e_q;
            if (a_s_q == b_s_q) begin
               sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
               z_s_d = a_s_q;
            end else if (a_m_q >= b_m_q) begin
               sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
               z_s_d = a_s_q;
            end else begin
               sum_d = {1'b0, b_m_q} - {1'b0, a_m_q};
               z_s_d = b_s_q;
            end
            state_d = ADD1;
         end
         ADD1: begin
            if (sum_q[27]) begin
               z_m_d = sum_q[27:4];
               g_d = sum_q[3];
               r_d = sum_q[2];
               s_d = sum_q[1] | sum_q[0];
               z_e_d = z_e_q + 10'sd1;
            end else begin
               z_m_d = sum_q[26:3];
               g_d = sum_q[2];
               r_d = sum_q[1];
               s_d = sum_q[0];
            end
            state_d = NORM1;
         end
         NORM1: begin
            if (!z_m_q[23] && (z_e_q > EMIN)) begin
               z_e_d = z_e_q - 10'sd1;
               z_m_d = {z_m_q[22:0], g_q};
               g_d = r_q;
               r_d = 1'b0;
            end else begin
               state_d = NORM2;
            end
         end
         NORM2: begin
            if (z_e_q < EMIN) begin
               z_e_d = z_e_q + 10'sd1;
               z_m_d = {1'b0, z_m_q[23:1]};
               g_d = z_m_q[0];
               r_d = g_q;
               s_d = s_q | r_q;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (rnd[24]) begin
               z_m_d = 24'h80_0000;
               z_e_d = z_e_q + 10'sd1;
            end else begin
               z_m_d = rnd[23:0];
            end
            state_d = PACK;
         end
         PACK: begin
            z_d = {z_s_q, biased[7:0], z_m_q[22:0]};
            if ((z_e_q == EMIN) && !z_m_q[23]) z_d[30:23] = 8'd0;
            if (z_e_q > EMAX) begin
               z_d = {z_s_q, POS_INF[30:0]};
            end else if (z_m_q == 24'd0) begin
               z_d = 32'd0;
            end
            state_d = PUT_Z;
         end
         PUT_Z: begin
            z_stb_d = 1'b1;
            if (z_stb_q && bus.ack_output) begin
               z_stb_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         z_q <= '0;
         a_m_q <= '0;
         b_m_q <= '0;
         sum_q <= '0;
         z_m_q <= '0;
         a_e_q <= '0;
         b_e_q <= '0;
         z_e_q <= '0;
         a_s_q <= 1'b0;
         b_s_q <= 1'b0;
         z_s_q <= 1'b0;
         g_q <= 1'b0;
         r_q <= 1'b0;
         s_q <= 1'b0;
         z_stb_q <= 1'b0;
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         z_q <= z_d;
         a_m_q <= a_m_d;
         b_m_q <= b_m_d;
         sum_q <= sum_d;
         z_m_q <= z_m_d;
         a_e_q <= a_e_d;
         b_e_q <= b_e_d;
         z_e_q <= z_e_d;
         a_s_q <= a_s_d;
         b_s_q <= b_s_d;
         z_s_q <= z_s_d;
         g_q <= g_d;
         r_q <= r_d;
         s_q <= s_d;
         z_stb_q <= z_stb_d;
         a_ack_q <= a_ack_d;
         b_ack_q <= b_ack_d;
      end
   end

   assign bus.output_z     = z_q;
   assign bus.output_z_stb = z_stb_q;
   assign bus.input_a_ack  = a_ack_q;
   assign bus.input_b_ack  = b_ack_q;

endmodule

// File: tb/tb_fp_adder.sv
// Directed-vector bench for fp_adder: arithmetic table plus handshake,
// start gating and asynchronous reset sequences.
module tb_fp_adder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   fp_adder_if bus ();

   fp_adder dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] z;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic wait_stb(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.output_z_stb) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_op(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      bit ok;
      @(negedge clk);
      bus.input_a = a;
      bus.input_b = b;
      bus.input_a_stb = 1'b1;
      bus.input_b_stb = 1'b1;
      bus.ack_output = 1'b1;
      bus.start = 1'b1;
      wait_stb(3000, ok);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s: timeout waiting for output_z_stb", name);
      end else begin
         check(name, bus.output_z, exp);
      end
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bit ok;
      bit seen_ack;

      vecs[0]  = '{"add_15p75_7p25", 32'h417C0000, 32'h40E80000, 32'h41B80000};
      vecs[1]  = '{"cancel_zero",    32'h3F800000, 32'hBF800000, 32'h00000000};
      vecs[2]  = '{"inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000};
      vecs[3]  = '{"nan_in",         32'h7FC00001, 32'h3F800000, 32'h7FC00000};
      vecs[4]  = '{"tie_even_down",  32'h3F800000, 32'h33800000, 32'h3F800000};
      vecs[5]  = '{"tie_odd_up",     32'h3F800001, 32'h33800000, 32'h3F800002};
      vecs[6]  = '{"denorm_sum",     32'h00000001, 32'h00000001, 32'h00000002};
      vecs[7]  = '{"overflow_inf",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
      vecs[8]  = '{"one_plus_two",   32'h3F800000, 32'h40000000, 32'h40400000};
      vecs[9]  = '{"neg_larger",     32'hC0200000, 32'h3F800000, 32'hBFC00000};
      vecs[10] = '{"neg_zeros",      32'h80000000, 32'h80000000, 32'h80000000};
      vecs[11] = '{"inf_plus_one",   32'h7F800000, 32'h3F800000, 32'h7F800000};
      vecs[12] = '{"norm_to_denorm", 32'h00800000, 32'h80000001, 32'h007FFFFF};
      vecs[13] = '{"renormalise",    32'h3FC00000, 32'hBFA00000, 32'h3E800000};

      bus.input_a = '0;
      bus.input_b = '0;
      bus.input_a_stb = 1'b0;
      bus.input_b_stb = 1'b0;
      bus.ack_output = 1'b0;
      bus.start = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_z", bus.output_z, 32'd0);
      check("reset_stb", {31'd0, bus.output_z_stb}, 32'd0);
      check("reset_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
      check("reset_b_ack", {31'd0, bus.input_b_ack}, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 14; i++)
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].z);

      // start low: stbs present but no acks may appear
      bus.input_a_stb = 1'b1;
      bus.input_b_stb = 1'b1;
      bus.start = 1'b0;
      seen_ack = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.input_a_ack || bus.input_b_ack) seen_ack = 1'b1;
      end
      check("no_ack_without_start", {31'd0, seen_ack}, 32'd0);

      // B stall then output hold
      bus.input_a = 32'h3F800000;
      bus.input_b = 32'h40000000;
      bus.input_b_stb = 1'b0;
      bus.ack_output = 1'b0;
      bus.start = 1'b1;
      repeat (8) @(negedge clk);
      check("stall_b_ack", {31'd0, bus.input_b_ack}, 32'd1);
      check("stall_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
      check("stall_no_stb", {31'd0, bus.output_z_stb}, 32'd0);
      bus.input_b_stb = 1'b1;
      wait_stb(200, ok);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL hold_result: timeout waiting for output_z_stb");
      end else begin
         check("hold_result", bus.output_z, 32'h40400000);
      end
      repeat (5) @(negedge clk);
      check("hold_stb", {31'd0, bus.output_z_stb}, 32'd1);
      check("hold_z", bus.output_z, 32'h40400000);
      bus.ack_output = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      check("release_stb", {31'd0, bus.output_z_stb}, 32'd0);

      // asynchronous reset while aligning
      bus.input_a = 32'h3F800000;
      bus.input_b = 32'h33800000;
      bus.start = 1'b1;
      seen_ack = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.input_b_ack) begin
            seen_ack = 1'b1;
            break;
         end
      end
      check("mid_op_b_ack", {31'd0, seen_ack}, 32'd1);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_z", bus.output_z, 32'd0);
      check("async_rst_stb", {31'd0, bus.output_z_stb}, 32'd0);
      check("async_rst_acks",
            {30'd0, bus.input_a_ack, bus.input_b_ack}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op("after_reset", 32'h417C0000, 32'h40E80000, 32'h41B80000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
